// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, inverse S-box table and the
// state encoding of the iterative InvSubBytes stage.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int BYTES   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } inv_sb_state_e;

    // FIPS-197 inverse S-box, indexed by the input byte value
    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_inv_sub_bytes_seq_if.sv
// Valid/ready stream carrying one AES state per transfer.
interface aes_inv_sub_bytes_seq_if
    import aes_pkg::*;
#(
    parameter int DATA_W = STATE_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box lookup for one byte; shared with the
// key-schedule / decrypt datapath.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = INV_SBOX[byte_i];
endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative InvSubBytes: captures a 128-bit state, substitutes LANES bytes
// per cycle in ascending byte order, then holds the result until accepted.
module aes_inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aes_inv_sub_bytes_seq_if.slave   in_if,
    aes_inv_sub_bytes_seq_if.master  out_if
);
    localparam int GROUPS = BYTES / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int IDX_W  = $clog2(BYTES);
    localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

    // Element 0 is the most significant byte, matching the state byte order
    typedef logic [0:BYTES-1][7:0] state_bytes_t;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    inv_sb_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_bytes_t     work_q, work_d;
    state_bytes_t     out_data_q, out_data_d;
    state_bytes_t     sub_state;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [IDX_W-1:0] lane_idx [LANES];
    logic [7:0]       lane_in  [LANES];
    logic [7:0]       lane_out [LANES];

    // One inverse S-box per lane, fed from the current group of the working register
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_idx[gi] = IDX_W'(int'(cnt_q) * LANES + gi);
        assign lane_in[gi]  = work_q[lane_idx[gi]];
        aes_inv_sbox u_sbox (
            .byte_i (lane_in[gi]),
            .byte_o (lane_out[gi])
        );
    end

    // Working register with the current group replaced by its substituted bytes
    always_comb begin
        sub_state = work_q;
        for (int l = 0; l < LANES; l++) begin
            sub_state[lane_idx[l]] = lane_out[l];
        end
    end

    // Next-state logic for the IDLE -> BUSY -> DONE sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        out_data_d  = out_data_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_if.valid && in_ready_q) begin
                    work_d     = in_if.data;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                work_d = sub_state;
                if (cnt_q == LAST_GRP) begin
                    // Only a complete block ever reaches the output register
                    out_data_d  = sub_state;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                // Input stays blocked this cycle even if in_valid is high
                if (out_if.ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any block in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_seq.sv
// Directed and randomised checks of aes_inv_sub_bytes_seq for all legal LANES.
module tb_aes_inv_sub_bytes_seq;

    localparam int NDUT = 5;   // index 0: LANES=4, then 1, 2, 8, 16

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    logic [NDUT-1:0] in_ready_v;
    logic [NDUT-1:0] out_valid_v;
    logic [127:0]    out_data_v [NDUT];

    int checks;
    int errors;

    logic [7:0] ref_inv [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 8 : 16;
        aes_inv_sub_bytes_seq_if #(.DATA_W(128)) in_if ();
        aes_inv_sub_bytes_seq_if #(.DATA_W(128)) out_if ();
        assign in_if.valid     = in_valid;
        assign in_if.data      = in_data;
        assign out_if.ready    = out_ready;
        assign in_ready_v[gi]  = in_if.ready;
        assign out_valid_v[gi] = out_if.valid;
        assign out_data_v[gi]  = out_if.data;
        aes_inv_sub_bytes_seq #(.LANES(L)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .in_if  (in_if),
            .out_if (out_if)
        );
    end

    // Reference inverse S-box derived from GF(2^8) inversion and the affine map
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127 - 8*k -: 8] = ref_inv[s[127 - 8*k -: 8]];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (3) step();
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (in_ready_v[d] !== 1'b1) begin errors++; $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, in_ready_v[d]); end
            checks++;
            if (out_valid_v[d] !== 1'b0) begin errors++; $display("FAIL reset_out_valid dut%0d: got %b expected 0", d, out_valid_v[d]); end
            checks++;
            if (out_data_v[d] !== 128'h0) begin errors++; $display("FAIL reset_out_data dut%0d: got %h expected 0", d, out_data_v[d]); end
        end
        rst_n = 1'b1;
        step();
        $display("reset: done");
    endtask

    task automatic test_all_63();
        int lat = 0;
        in_data = {16{8'h63}}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid_v[0] && lat < 40) begin step(); lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL all63_latency: got %0d expected 4", lat); end
        checks++;
        if (out_data_v[0] !== 128'h0) begin errors++; $display("FAIL all63_data: got %h expected 0", out_data_v[0]); end
        step();
        checks++;
        if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL all63_valid_one_cycle: got %b expected 0", out_valid_v[0]); end
        checks++;
        if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL all63_back_idle: got %b expected 1", in_ready_v[0]); end
        $display("all63: in=%h out latency=%0d", {16{8'h63}}, lat);
    endtask

    task automatic test_lanes();
        int           exp_lat [NDUT] = '{4, 16, 8, 2, 1};
        int           lat     [NDUT];
        logic [127:0] got     [NDUT];
        logic [NDUT-1:0] seen = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        in_data = 128'h000102030405060708090a0b0c0d0e0f; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            step();
            for (int d = 0; d < NDUT; d++) begin
                if (out_valid_v[d] && !seen[d]) begin
                    seen[d] = 1'b1; lat[d] = c; got[d] = out_data_v[d];
                end
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (!seen[d]) begin
                errors++; $display("FAIL lanes_timeout dut%0d: got no out_valid expected latency %0d", d, exp_lat[d]);
            end else begin
                checks++;
                if (lat[d] !== exp_lat[d]) begin errors++; $display("FAIL lanes_latency dut%0d: got %0d expected %0d", d, lat[d], exp_lat[d]); end
                checks++;
                if (got[d] !== 128'h52096ad53036a538bf40a39e81f3d7fb) begin
                    errors++; $display("FAIL lanes_data dut%0d: got %h expected 52096ad53036a538bf40a39e81f3d7fb", d, got[d]);
                end
                $display("lanes: dut%0d latency=%0d out=%h", d, lat[d], got[d]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat = 0;
        in_data = '0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        while (!out_valid_v[0] && lat < 40) begin step(); lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", lat); end
        for (int c = 0; c < 10; c++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            checks++;
            if (out_valid_v[0] !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc%0d: got %b expected 1", c, out_valid_v[0]); end
            checks++;
            if (out_data_v[0] !== {16{8'h52}}) begin errors++; $display("FAIL bp_hold_data cyc%0d: got %h expected %h", c, out_data_v[0], {16{8'h52}}); end
            checks++;
            if (in_ready_v[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", c, in_ready_v[0]); end
        end
        // Release together with a new input: deliver now, accept one cycle later
        in_data = {16{8'hff}}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        checks++;
        if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid_v[0]); end
        checks++;
        if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL bp_release_not_accepted: got %b expected 1", in_ready_v[0]); end
        step();
        in_valid = 1'b0;
        checks++;
        if (in_ready_v[0] !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got %b expected 0", in_ready_v[0]); end
        lat = 0;
        while (!out_valid_v[0] && lat < 40) begin step(); lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL bp_ff_latency: got %0d expected 4", lat); end
        checks++;
        if (out_data_v[0] !== {16{8'h7d}}) begin errors++; $display("FAIL bp_ff_data: got %h expected %h", out_data_v[0], {16{8'h7d}}); end
        step();
        $display("backpressure: held %h for 10 cycles, then ff -> %h", {16{8'h52}}, {16{8'h7d}});
    endtask

    task automatic test_reset_midop();
        int lat = 0;
        in_data = {16{8'hff}}; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid_v[0]); end
        checks++;
        if (out_data_v[0] !== 128'h0) begin errors++; $display("FAIL midrst_out_data: got %h expected 0", out_data_v[0]); end
        checks++;
        if (in_ready_v[0] !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready_v[0]); end
        step();
        rst_n = 1'b1;
        step();
        in_data = {16{8'h7c}}; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid_v[0] && lat < 40) begin step(); lat++; end
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 4", lat); end
        checks++;
        if (out_data_v[0] !== {16{8'h01}}) begin errors++; $display("FAIL midrst_next_data: got %h expected %h", out_data_v[0], {16{8'h01}}); end
        step();
        $display("reset_midop: next block 7c.. -> %h", {16{8'h01}});
    endtask

    task automatic test_back_to_back();
        localparam int N = 20;
        logic [127:0] exp_q [$];
        logic [127:0] exp_v;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        logic accepted;
        in_valid = 1'b0; out_ready = 1'b0;
        while (recv < N && cyc < 3000) begin
            if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid_v[0] && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: got %h expected no output", out_data_v[0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out_data_v[0] !== exp_v) begin
                        errors++; $display("FAIL b2b_data blk%0d: got %h expected %h", recv, out_data_v[0], exp_v);
                    end
                    $display("b2b: blk%0d out=%h", recv, out_data_v[0]);
                end
                recv++;
            end
            accepted = in_valid && in_ready_v[0];
            if (accepted) begin
                exp_q.push_back(model_state(in_data));
                sent++;
            end
            step();
            cyc++;
            if (accepted) in_valid = 1'b0;
        end
        checks++;
        if (recv !== N) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", recv, N); end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks++;
            if (out_valid_v[0] !== 1'b0) begin errors++; $display("FAIL b2b_extra_output cyc%0d: got %b expected 0", c, out_valid_v[0]); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        for (int x = 0; x < 256; x++) ref_inv[fwd_sbox(8'(x))] = 8'(x);
        test_reset();
        test_all_63();
        test_lanes();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_inv_sub_bytes_seq.md
Name: aes_inv_sub_bytes_seq

Overview:
- Iterative InvSubBytes stage for the AES decryption round. It sits directly downstream of the inverse ShiftRows stage and consumes its 128-bit state.
- Substitutes all 16 state bytes through the FIPS-197 inverse S-box, LANES bytes per cycle, so area can be traded against latency.
- Uses a valid/ready handshake on both sides. The result is held until the consumer (AddRoundKey / InvMixColumns path) accepts it.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16 (must divide 16); any other value is an elaboration error.
- GROUPS, 16/LANES (derived localparam, not overridable), cycles per block.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream state available.
- in_ready  out  1  block can accept a state.
- in_data  in  128  state from inverse ShiftRows; bits [0:127], byte k = bits [8k +: 8], byte 0 = MSB.
- out_valid  out  1  substituted state available.
- out_ready  in  1  downstream accepts the state.
- out_data  out  128  substituted state, same byte ordering as in_data.

Behaviour:
- Reset is asynchronous, active-low, and takes effect mid-operation.
  - State goes to IDLE; in_ready=1, out_valid=0, out_data=0, group counter=0.
  - Any block in flight is discarded; no partial result ever appears.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&in_ready, capture in_data into the working register, clear the counter, go to BUSY.
  - BUSY: in_ready=0, out_valid=0. Each cycle, replace bytes [cnt*LANES .. cnt*LANES+LANES-1] of the working register with INV_SBOX(byte) and increment cnt. When cnt==GROUPS-1, write the last group and go to DONE.
  - DONE: out_valid=1, and out_data equals the fully substituted register, stable. On out_ready go to IDLE. in_ready=0 in DONE (no overlap).
- Latency: a block accepted at edge T gives out_valid=1 after edge T+GROUPS (LANES=4: 4 cycles; LANES=16: 1 cycle).
- Throughput: one block per GROUPS+2 cycles when out_ready is held high.
- Bytes are processed in ascending index order. Bytes not yet processed keep their captured value and are never visible at out_data while out_valid=0.
- Counter width is clog2(GROUPS), with a minimum of 1 bit. cnt never wraps outside BUSY and is cleared on every accept.
- Backpressure: out_valid stays high and out_data stays unchanged until out_ready=1. out_ready while out_valid=0 has no effect.
- in_data changing while BUSY/DONE has no effect (captured at accept only).
- in_valid and out_ready high in the same DONE cycle: the result is delivered, state goes to IDLE, and the new input is not accepted until the next cycle.
- out_data is driven from the register, with no combinational path from in_data or in_valid.

Decomposition:
- Package aes_pkg:
  - STATE_W=128, BYTES=16.
  - INV_SBOX[0:255] 8-bit constant table (FIPS-197).
  - State-machine enum {IDLE, BUSY, DONE}.
- Sub-module aes_inv_sbox: combinational 8-bit in to 8-bit out lookup from INV_SBOX, instantiated LANES times. The same sub-module is reused later by the key-schedule/decrypt datapath.

Test Plan:
- All-0x63 state (0x6363...63), LANES=4, out_ready=1: out_data=0x000...0, with out_valid rising exactly 4 cycles after accept and high for 1 cycle.
- in_data=0x000102030405060708090a0b0c0d0e0f: out_data=0x52096ad53036a538bf40a39e81f3d7fb. Repeat for LANES=1, 2, 8, 16, checking latency is 16, 8, 2, 1 cycles.
- All-0x00 state with out_ready=0 for 10 cycles after out_valid: out_data holds 0x5252...52, in_ready stays 0, and in_data toggling is ignored. On out_ready=1, one transfer happens and the block goes to IDLE.
- rst_n pulsed low in the 2nd BUSY cycle (input 0xffff...ff): outputs immediately go to out_valid=0, out_data=0, in_ready=1. A following block 0x7c7c...7c yields 0x0101...01 with no corruption.
- Back-to-back random blocks against a reference inverse S-box model, with random in_valid/out_ready gaps: every accepted block appears exactly once, in order, bit-exact.
